vec_serial_exec: RTL and testbench

VEC_SERIAL_EXEC -- requirements
Module: vec_serial_exec

---
 rtl/vec_pkg.sv | 31 +++
 rtl/vec_lane_alu.sv | 26 ++
 rtl/vec_serial_exec.sv | 90 +++++++++
 tb/tb_vec_serial_exec.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared types for the serial vector executor: opcodes, FSM states,
// default geometry and the opcode legality check (VEC_MUL_EN enables mul).
package vec_pkg;

  localparam int VEC_LANES = 4;
  localparam int VEC_WIDTH = 32;

  typedef enum logic [2:0] {
    VOP_ADD = 3'b000,
    VOP_SUB = 3'b001,
    VOP_MUL = 3'b010
  } vop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } vstate_e;

  function automatic logic vop_legal(
    input logic [2:0] op
  );
    logic ok;
    ok = (op == VOP_ADD) || (op == VOP_SUB);
`ifdef VEC_MUL_EN
    ok = ok || (op == VOP_MUL);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// Combinational single-lane add/sub (mul when VEC_MUL_EN is defined).
// Ports: op (3b opcode), a/b (WIDTH operands), y (WIDTH result, modulo 2^WIDTH).
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int WIDTH = VEC_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (1'b1)
      (op == VOP_ADD): y = a + b;
      (op == VOP_SUB): y = a - b;
`ifdef VEC_MUL_EN
      (op == VOP_MUL): y = a * b;
`endif
      default:         y = '0;
    endcase
  end

endmodule

// File: rtl/vec_serial_exec.sv
// Serial vector executor: one lane per clock through a shared lane ALU.
// Ports: clk, rst_n, req_* (valid/ready, op, a, b), rsp_* (valid/ready, result, err).
// Macro VEC_MUL_EN makes opcode 010 legal and builds the lane multiplier.
module vec_serial_exec
  import vec_pkg::*;
#(
  parameter int LANES = VEC_LANES,
  parameter int WIDTH = VEC_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_op,
  input  logic [LANES*WIDTH-1:0] req_a,
  input  logic [LANES*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [LANES*WIDTH-1:0] rsp_result,
  output logic                   rsp_err
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  vstate_e                       state;
  logic [CW-1:0]                 cnt;
  logic [2:0]                    op_q;
  logic [LANES-1:0][WIDTH-1:0]   a_q;
  logic [LANES-1:0][WIDTH-1:0]   b_q;
  logic [LANES-1:0][WIDTH-1:0]   res_q;
  logic                          err_q;
  logic [WIDTH-1:0]              lane_y;

  vec_lane_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op(op_q),
    .a (a_q[cnt]),
    .b (b_q[cnt]),
    .y (lane_y)
  );

  assign req_ready  = (state == ST_IDLE);
  assign rsp_valid  = (state == ST_DONE);
  assign rsp_result = res_q;
  assign rsp_err    = err_q;

  // Illegal ops pass through EXEC for exactly one edge with err set,
  // giving the required single-edge latency without touching the ALU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q  <= req_op;
            a_q   <= req_a;
            b_q   <= req_b;
            cnt   <= '0;
            res_q <= '0;
            err_q <= !vop_legal(req_op);
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (err_q) begin
            state <= ST_DONE;
          end else begin
            res_q[cnt] <= lane_y;
            cnt        <= cnt + CW'(1);
            if (cnt == LAST) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_serial_exec.sv
// Self-checking bench for vec_serial_exec: directed table, random ops
// against a lane-wise arithmetic model, backpressure and mid-EXEC reset.
module tb_vec_serial_exec;

  localparam int LANES = 4;
  localparam int WIDTH = 32;
  localparam int VW    = LANES * WIDTH;
`ifdef VEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef logic [VW-1:0] vec_t;

  typedef struct {
    string      name;
    logic [2:0] op;
    vec_t       a;
    vec_t       b;
    vec_t       res;
    logic       err;
    int         lat;
  } vec_rec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = '0;
  vec_t       req_a = '0;
  vec_t       req_b = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  vec_t       rsp_result;
  logic       rsp_err;

  int tests = 0;
  int fails = 0;

  vec_serial_exec #(
    .LANES(LANES),
    .WIDTH(WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t pack4(
    input logic [31:0] l0, l1, l2, l3
  );
    return {l3, l2, l1, l0};
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 5))
        0: v[i*WIDTH +: WIDTH] = '1;
        1: v[i*WIDTH +: WIDTH] = '0;
        default: v[i*WIDTH +: WIDTH] = $urandom;
      endcase
    end
    return v;
  endfunction

  task automatic model(
    input  logic [2:0] op,
    input  vec_t       a,
    input  vec_t       b,
    output vec_t       r,
    output logic       e,
    output int         lat
  );
    longint unsigned x, y, m;
    m = 64'd1 << WIDTH;
    e = !(op == 3'd0 || op == 3'd1 || (MUL_EN && op == 3'd2));
    lat = e ? 1 : LANES;
    r = '0;
    if (!e) begin
      for (int i = 0; i < LANES; i++) begin
        x = a[i*WIDTH +: WIDTH];
        y = b[i*WIDTH +: WIDTH];
        if (op == 3'd0) r[i*WIDTH +: WIDTH] = WIDTH'((x + y) % m);
        else if (op == 3'd1) r[i*WIDTH +: WIDTH] = WIDTH'((x + m - y) % m);
        else r[i*WIDTH +: WIDTH] = WIDTH'((x * y) % m);
      end
    end
  endtask

  task automatic chk(
    input string        name,
    input logic [VW-1:0] act,
    input logic [VW-1:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(
    input  string      name,
    input  logic [2:0] op,
    input  vec_t       a,
    input  vec_t       b,
    input  int         hold,
    output vec_t       res,
    output logic       err,
    output int         lat
  );
    @(negedge clk);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    chk({name, ".req_ready"}, VW'(req_ready), VW'(1));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 3'($urandom_range(0, 7));
    req_a     = rnd_vec();
    req_b     = rnd_vec();
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) lat = n;
    end
    if (lat == 0) begin
      tests++;
      fails++;
      $display("FAIL %s.timeout: no rsp_valid within 20 edges", name);
    end
    res = rsp_result;
    err = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk({name, ".hold_valid"}, VW'(rsp_valid), VW'(1));
      chk({name, ".hold_result"}, rsp_result, res);
      chk({name, ".hold_err"}, VW'(rsp_err), VW'(err));
      chk({name, ".hold_req_ready"}, VW'(req_ready), VW'(0));
      req_valid = 1'($urandom_range(0, 1));
      req_op    = 3'($urandom_range(0, 7));
      req_a     = rnd_vec();
      req_b     = rnd_vec();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({name, ".post_valid"}, VW'(rsp_valid), VW'(0));
    chk({name, ".post_req_ready"}, VW'(req_ready), VW'(1));
    chk({name, ".post_result"}, rsp_result, res);
    chk({name, ".post_err"}, VW'(rsp_err), VW'(err));
  endtask

  initial begin
    vec_rec_t tbl[$];
    vec_t va, vb, res, er;
    logic err, ee;
    int lat, el;

    va = pack4(32'h5, 32'h8, 32'h12, 32'h20);
    vb = pack4(32'h2, 32'h4, 32'h6, 32'h10);
    tbl.push_back('{"add", 3'b000, va, vb,
                    pack4(32'h7, 32'hC, 32'h18, 32'h30), 1'b0, 4});
    tbl.push_back('{"sub", 3'b001, va, vb,
                    pack4(32'h3, 32'h4, 32'hC, 32'h10), 1'b0, 4});
    tbl.push_back('{"mul", 3'b010, va, vb,
                    MUL_EN ? pack4(32'hA, 32'h20, 32'h6C, 32'h200) : '0,
                    !MUL_EN, MUL_EN ? 4 : 1});
    tbl.push_back('{"ill111", 3'b111, va, vb, '0, 1'b1, 1});
    tbl.push_back('{"add", 3'b000, va, vb,
                    pack4(32'h7, 32'hC, 32'h18, 32'h30), 1'b0, 4});
    tbl.push_back('{"wrap_add", 3'b000,
                    pack4(32'hFFFFFFFF, 32'h0, 32'h7FFFFFFF, 32'h1),
                    pack4(32'h1, 32'h1, 32'h1, 32'hFFFFFFFF),
                    pack4(32'h0, 32'h1, 32'h80000000, 32'h0), 1'b0, 4});
    tbl.push_back('{"wrap_sub", 3'b001,
                    pack4(32'hFFFFFFFF, 32'h0, 32'h7FFFFFFF, 32'h1),
                    pack4(32'h1, 32'h1, 32'h1, 32'hFFFFFFFF),
                    pack4(32'hFFFFFFFE, 32'hFFFFFFFF, 32'h7FFFFFFE, 32'h2),
                    1'b0, 4});
    tbl.push_back('{"ill011", 3'b011, va, vb, '0, 1'b1, 1});

    #1;
    chk("rst.valid", VW'(rsp_valid), VW'(0));
    chk("rst.result", rsp_result, '0);
    chk("rst.err", VW'(rsp_err), VW'(0));
    chk("rst.req_ready", VW'(req_ready), VW'(1));
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b,
             (i == 0) ? 5 : 0, res, err, lat);
      chk({tbl[i].name, ".lat"}, VW'(lat), VW'(tbl[i].lat));
      chk({tbl[i].name, ".result"}, res, tbl[i].res);
      chk({tbl[i].name, ".err"}, VW'(err), VW'(tbl[i].err));
    end

    for (int k = 0; k < 40; k++) begin
      logic [2:0] op;
      op = (k % 4 == 3) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      va = rnd_vec();
      vb = rnd_vec();
      model(op, va, vb, er, ee, el);
      run_op("rnd", op, va, vb, $urandom_range(0, 2), res, err, lat);
      chk("rnd.lat", VW'(lat), VW'(el));
      chk("rnd.result", res, er);
      chk("rnd.err", VW'(err), VW'(ee));
    end

    // Reset while lane 2 is the next lane to be computed.
    @(negedge clk);
    req_op    = 3'b000;
    req_a     = pack4(32'h5, 32'h8, 32'h12, 32'h20);
    req_b     = pack4(32'h2, 32'h4, 32'h6, 32'h10);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.valid", VW'(rsp_valid), VW'(0));
    chk("mid_rst.result", rsp_result, '0);
    chk("mid_rst.err", VW'(rsp_err), VW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      chk("mid_rst.no_valid", VW'(rsp_valid), VW'(0));
      chk("mid_rst.req_ready", VW'(req_ready), VW'(1));
    end
    va = pack4(32'h5, 32'h8, 32'h12, 32'h20);
    vb = pack4(32'h2, 32'h4, 32'h6, 32'h10);
    run_op("post_rst", 3'b000, va, vb, 0, res, err, lat);
    chk("post_rst.lat", VW'(lat), VW'(4));
    chk("post_rst.result", res, pack4(32'h7, 32'hC, 32'h18, 32'h30));
    chk("post_rst.err", VW'(err), VW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
